// File: rtl/matrix_scan_capture.sv
// matrix_scan_capture
// Receive side of a 5x7 column-scanned LED matrix. Each column strobe must sit
// still long enough to be trusted before its row pattern is taken. Columns have
// to arrive as C0..C4 in order before a frame is published. Protocol faults are
// kept in sticky flags, and a watchdog reports a scan that has stopped.

// One column of the frame being assembled: the last settled row pattern seen
// while this column was strobed.
module msc_col_slot #(
    parameter int NUM_ROWS = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wrEn,
    input  logic [NUM_ROWS-1:0] rowIn,
    output logic [NUM_ROWS-1:0] rowQ
);
    // Latch the row pattern when this column's dwell completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    rowQ <= '0;
        else if (wrEn) rowQ <= rowIn;
    end
endmodule

module matrix_scan_capture #(
    parameter int SETTLE     = 2,
    parameter int TIMEOUT    = 65535,
    parameter bit COL_ACT_LO = 1'b0,
    parameter bit ROW_ACT_LO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  col,
    input  logic [6:0]  row,
    input  logic        clr_err,
    output logic [34:0] frame,
    output logic        frame_valid,
    output logic        frame_chg,
    output logic        err_order,
    output logic        err_invalid,
    output logic        stalled
);
    localparam int NUM_COLS = 5;
    localparam int NUM_ROWS = 7;
    localparam int DCW      = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam int IW       = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    // Dwell counter saturates at SETTLE. The event fires on the step into saturation.
    localparam logic [DCW-1:0] DWELL_MAX = DCW'(SETTLE);
    localparam logic [DCW-1:0] DWELL_ARM = DCW'((SETTLE < 1) ? 0 : SETTLE - 1);
    // The idle counter saturates at TIMEOUT. Stalled rises on the step into saturation.
    localparam logic [IW-1:0]  IDLE_MAX  = IW'(TIMEOUT);
    localparam logic [IW-1:0]  IDLE_ARM  = IW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);
    localparam logic [2:0]     LAST_COL  = 3'(NUM_COLS - 1);

    typedef enum logic [1:0] {
        S_HUNT, // waiting for a C0 dwell to start a frame
        S_CAP,  // collecting columns, expIdx is the next one wanted
        S_PUB   // C4 just landed; publish on this edge, behave like HUNT
    } stateT;

    logic [NUM_COLS-1:0]                colN;
    logic [NUM_ROWS-1:0]                rowN;
    logic [NUM_COLS-1:0]                colQ;
    logic [DCW-1:0]                     dwellCnt;
    logic                               dwellEvt;
    logic                               colOneHot;
    logic [2:0]                         colIdx;
    logic                               colDone;
    logic                               setOrder;
    logic                               setInvalid;
    logic                               stallHit;
    logic [IW-1:0]                      idleCnt;
    logic [NUM_COLS-1:0][NUM_ROWS-1:0]  shadow;
    stateT                              state;
    stateT                              stateNext;
    logic [2:0]                         expIdx;
    logic [2:0]                         expNext;

    // Both lines are normalised to active-high before anything else looks at them.
    assign colN = COL_ACT_LO ? ~col : col;
    assign rowN = ROW_ACT_LO ? ~row : row;

    assign colOneHot  = (colN != '0) && ((colN & (colN - 5'd1)) == '0);
    assign colDone    = dwellEvt && colOneHot;
    assign setInvalid = dwellEvt && !colOneHot;
    // Only a valid column keeps the watchdog quiet. Invalid patterns do not count.
    assign stallHit   = !colDone && (idleCnt == IDLE_ARM);

    // One-hot to index. It is only meaningful when colOneHot is set.
    always_comb begin
        colIdx = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (colN[i]) colIdx = 3'(i);
        end
    end

    // Register the column pattern and count how long it has stayed unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colQ     <= '0;
            dwellCnt <= '0;
        end else begin
            colQ <= colN;
            if (colN == colQ) begin
                if (dwellCnt != DWELL_MAX) dwellCnt <= dwellCnt + 1'b1;
            end else begin
                dwellCnt <= '0;
            end
        end
    end

    // SETTLE=0 trusts a column on the first edge after it changes. Otherwise the
    // pattern must survive SETTLE more edges, and the event fires only once.
    generate
        if (SETTLE == 0) begin : gEvtImm
            assign dwellEvt = (colN != colQ);
        end else begin : gEvtDwell
            assign dwellEvt = (colN == colQ) && (dwellCnt == DWELL_ARM);
        end
    endgenerate

    // Any settled one-hot column refreshes its shadow slot, whatever the FSM
    // is doing. Publishing requires a complete in-order pass, so stale slots
    // never reach the frame output.
    for (genvar c = 0; c < NUM_COLS; c++) begin : gSlot
        msc_col_slot #(.NUM_ROWS(NUM_ROWS)) uSlot (
            .clk   (clk),
            .rst_n (rst_n),
            .wrEn  (colDone && colN[c]),
            .rowIn (rowN),
            .rowQ  (shadow[c])
        );
    end

    // Scan-order tracking: next state, next expected column, order fault.
    always_comb begin
        stateNext = state;
        expNext   = expIdx;
        setOrder  = 1'b0;
        case (state)
            S_HUNT, S_PUB: begin
                stateNext = S_HUNT;
                if (colDone && colIdx == 3'd0) begin
                    stateNext = S_CAP;
                    expNext   = 3'd1;
                end
            end
            S_CAP: begin
                if (colDone) begin
                    if (colIdx == expIdx) begin
                        if (expIdx == LAST_COL) stateNext = S_PUB;
                        else                    expNext   = expIdx + 3'd1;
                    end else begin
                        setOrder = 1'b1;
                        // A fresh C0 is a valid restart. Anything else drops the frame.
                        if (colIdx == 3'd0) expNext   = 3'd1;
                        else                stateNext = S_HUNT;
                    end
                end
            end
            default: stateNext = S_HUNT;
        endcase
        if (stallHit) stateNext = S_HUNT;
    end

    // FSM state and expected-column register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_HUNT;
            expIdx <= '0;
        end else begin
            state  <= stateNext;
            expIdx <= expNext;
        end
    end

    // Publish the assembled frame one edge after the C4 dwell event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame       <= '0;
            frame_valid <= 1'b0;
            frame_chg   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_chg   <= 1'b0;
            if (state == S_PUB) begin
                frame       <= shadow;
                frame_valid <= 1'b1;
                frame_chg   <= (shadow != frame);
            end
        end
    end

    // Sticky fault flags. A new fault in the same cycle overrides clr_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_order   <= 1'b0;
            err_invalid <= 1'b0;
        end else begin
            err_order   <= setOrder   | (err_order   & ~clr_err);
            err_invalid <= setInvalid | (err_invalid & ~clr_err);
        end
    end

    // Watchdog: count cycles since the last valid column, then hold stalled until one arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idleCnt <= '0;
            stalled <= 1'b0;
        end else if (colDone) begin
            idleCnt <= '0;
            stalled <= 1'b0;
        end else if (idleCnt != IDLE_MAX) begin
            idleCnt <= idleCnt + 1'b1;
            if (stallHit) stalled <= 1'b1;
        end
    end
endmodule

// File: tb/tb_matrix_scan_capture.sv
// Bench for matrix_scan_capture. Two instances run side by side. One has
// active-high lines; the other has active-low lines and is fed inverted
// stimulus. Both are checked against one behavioural model every cycle, with
// directed table segments and random scans layered on top.
module tb_matrix_scan_capture;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  col = '0;
    logic [6:0]  row = '0;
    logic        clrErr = 1'b0;
    logic [34:0] frameHi, frameLo;
    logic        fvHi, fvLo, fcHi, fcLo, eoHi, eoLo, eiHi, eiLo, stHi, stLo;
    int          nCmp = 0;
    int          nFail = 0;

    always #5 clk = ~clk;

    matrix_scan_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dutHi (
        .clk(clk), .rst_n(rst_n), .col(col), .row(row), .clr_err(clrErr),
        .frame(frameHi), .frame_valid(fvHi), .frame_chg(fcHi),
        .err_order(eoHi), .err_invalid(eiHi), .stalled(stHi)
    );

    matrix_scan_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT),
                          .COL_ACT_LO(1'b1), .ROW_ACT_LO(1'b1)) dutLo (
        .clk(clk), .rst_n(rst_n), .col(~col), .row(~row), .clr_err(clrErr),
        .frame(frameLo), .frame_valid(fvLo), .frame_chg(fcLo),
        .err_order(eoLo), .err_invalid(eiLo), .stalled(stLo)
    );

    // ---------------- behavioural reference model ----------------
    logic [4:0]  mPrev;
    int          mHeld;       // edges the current column value has been seen in a row
    logic [6:0]  mShadow [5];
    int          mNext;       // next column wanted in order, -1 while hunting for C0
    bit          mPub;
    logic [34:0] mFrame;
    bit          mValid, mChg, mEo, mEi, mStall;
    int          mIdle;

    task automatic modelReset();
        mPrev = '0; mHeld = 1; mNext = -1; mPub = 0;
        for (int c = 0; c < 5; c++) mShadow[c] = '0;
        mFrame = '0; mValid = 0; mChg = 0; mEo = 0; mEi = 0; mStall = 0; mIdle = 0;
    endtask

    function automatic logic [34:0] packShadow();
        logic [34:0] p;
        p = '0;
        for (int c = 0; c < 5; c++) p[c*7 +: 7] = mShadow[c];
        return p;
    endfunction

    task automatic modelEdge();
        bit evt, done, newOrd;
        int idx;
        logic [34:0] p;
        if (!rst_n) begin modelReset(); return; end
        mHeld = (col == mPrev) ? mHeld + 1 : 1;
        if (mHeld > 1000) mHeld = 1000;
        mPrev = col;
        evt = (mHeld == SETTLE + 1);
        mValid = 0; mChg = 0;
        if (mPub) begin
            p = packShadow();
            mChg = (p != mFrame);
            mFrame = p; mValid = 1; mPub = 0;
        end
        done = 0; newOrd = 0;
        if (evt && $countones(col) == 1) begin
            idx = $clog2(col);
            mShadow[idx] = row;
            done = 1;
            if (mNext < 0) begin
                if (idx == 0) mNext = 1;
            end else if (idx == mNext) begin
                if (mNext == 4) begin mPub = 1; mNext = -1; end
                else mNext++;
            end else begin
                newOrd = 1;
                mNext = (idx == 0) ? 1 : -1;
            end
        end
        mEo = newOrd | (mEo & !clrErr);
        mEi = (evt && $countones(col) != 1) | (mEi & !clrErr);
        if (done) begin
            mIdle = 0; mStall = 0;
        end else if (mIdle < TIMEOUT) begin
            mIdle++;
            if (mIdle == TIMEOUT) begin mStall = 1; mNext = -1; end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compareAll();
        logic [39:0] e;
        e = {mFrame, mValid, mChg, mEo, mEi, mStall};
        check("outHi", {frameHi, fvHi, fcHi, eoHi, eiHi, stHi}, e);
        check("outLo", {frameLo, fvLo, fcLo, eoLo, eiLo, stLo}, e);
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
        compareAll();
    endtask

    task automatic doReset(input int n);
        rst_n = 1'b0;
        #1;
        modelReset();
        compareAll();
        check("rstOuts", {frameHi, fvHi, fcHi, eoHi, eiHi, stHi}, 64'd0);
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    // Hold one column for n cycles and return how many frame_valid pulses appeared.
    task automatic hold(input logic [4:0] c, input logic [6:0] r, input int n, output int pulses);
        col = c; row = r; pulses = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if (fvHi) pulses++;
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [4:0]  c;
        logic [6:0]  r;
        int          hold;
        bit          clr;
        int          pulses;
        int          chgs;
        bit          eo;
        bit          ei;
        bit          chkFrame;
        logic [34:0] frm;
    } segT;

    segT tbl[$];

    function automatic segT mk(logic [4:0] c, logic [6:0] r, int h, bit clr, int p, int ch,
                               bit eo, bit ei, bit cf, logic [34:0] f);
        segT s;
        s.c = c; s.r = r; s.hold = h; s.clr = clr; s.pulses = p; s.chgs = ch;
        s.eo = eo; s.ei = ei; s.chkFrame = cf; s.frm = f;
        return s;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int pc, cc, at, stallAt, p, tot, r, hl, ptr;

        // One pixel per column on the diagonal.
        tbl.push_back(mk(5'b00001, 7'h01, 10, 0, 0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(5'b00010, 7'h02, 10, 0, 0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(5'b00100, 7'h04, 10, 0, 0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(5'b01000, 7'h08, 10, 0, 0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(5'b10000, 7'h10, 10, 0, 1, 1, 0, 0, 1, 35'h1_0101_0101));
        // The same scan again publishes, but frame_chg stays low.
        tbl.push_back(mk(5'b00001, 7'h01, 10, 0, 0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(5'b00010, 7'h02, 10, 0, 0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(5'b00100, 7'h04, 10, 0, 0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(5'b01000, 7'h08, 10, 0, 0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(5'b10000, 7'h10, 10, 0, 1, 0, 0, 0, 1, 35'h1_0101_0101));
        // C0, C1, C3 is an order fault; the full scan after it still publishes.
        tbl.push_back(mk(5'b00001, 7'h7f, 10, 0, 0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(5'b00010, 7'h7f, 10, 0, 0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(5'b01000, 7'h7f, 10, 0, 0, 0, 1, 0, 0, '0));
        tbl.push_back(mk(5'b00001, 7'h55, 10, 0, 0, 0, 1, 0, 0, '0));
        tbl.push_back(mk(5'b00010, 7'h2a, 10, 0, 0, 0, 1, 0, 0, '0));
        tbl.push_back(mk(5'b00100, 7'h7f, 10, 0, 0, 0, 1, 0, 0, '0));
        tbl.push_back(mk(5'b01000, 7'h00, 10, 0, 0, 0, 1, 0, 0, '0));
        tbl.push_back(mk(5'b10000, 7'h33, 10, 0, 1, 1, 1, 0, 1, 35'h3_301F_D555));
        tbl.push_back(mk(5'b10000, 7'h10,  3, 1, 0, 0, 0, 0, 0, '0));
        // A multi-hot column mid-frame, then a short C2 glitch and a one-cycle zero.
        tbl.push_back(mk(5'b00001, 7'h11, 10, 0, 0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(5'b00010, 7'h22, 10, 0, 0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(5'b00011, 7'h7f,  5, 0, 0, 0, 0, 1, 0, '0));
        tbl.push_back(mk(5'b00100, 7'h7f,  2, 0, 0, 0, 0, 1, 0, '0));
        tbl.push_back(mk(5'b00000, 7'h7f,  1, 0, 0, 0, 0, 1, 0, '0));
        tbl.push_back(mk(5'b00100, 7'h44, 10, 0, 0, 0, 0, 1, 0, '0));
        tbl.push_back(mk(5'b01000, 7'h08, 10, 0, 0, 0, 0, 1, 0, '0));
        tbl.push_back(mk(5'b10000, 7'h01, 10, 0, 1, 1, 0, 1, 1, 35'h0_1111_1111));
        tbl.push_back(mk(5'b10000, 7'h01,  2, 1, 0, 0, 0, 0, 0, '0));

        #2;
        doReset(2);

        foreach (tbl[i]) begin
            pc = 0; cc = 0; at = 0;
            col = tbl[i].c; row = tbl[i].r; clrErr = tbl[i].clr;
            for (int k = 1; k <= tbl[i].hold; k++) begin
                step();
                clrErr = 1'b0;
                if (fvHi) begin pc++; if (at == 0) at = k; end
                if (fcHi) cc++;
            end
            check($sformatf("seg%0d.pulses", i), pc, tbl[i].pulses);
            check($sformatf("seg%0d.chg", i), cc, tbl[i].chgs);
            check($sformatf("seg%0d.errOrder", i), eoHi, tbl[i].eo);
            check($sformatf("seg%0d.errInvalid", i), eiHi, tbl[i].ei);
            if (tbl[i].pulses > 0) check($sformatf("seg%0d.latency", i), at, SETTLE + 2);
            if (tbl[i].chkFrame) check($sformatf("seg%0d.frame", i), frameHi, tbl[i].frm);
        end

        // Stall: after reset no valid column arrives, so stalled rises at edge TIMEOUT.
        doReset(2);
        col = '0; row = '0; stallAt = 0;
        for (int k = 1; k <= TIMEOUT + 10; k++) begin
            step();
            if (stHi && stallAt == 0) stallAt = k;
        end
        check("stallAt", stallAt, TIMEOUT);
        col = 5'b00001; row = 7'h03;
        repeat (2) step();
        check("stallHeld", stHi, 1'b1);
        step();
        check("stallClr", stHi, 1'b0);
        repeat (2) step();
        tot = 0;
        hold(5'b00010, 7'h03, 5, p); tot += p;
        hold(5'b00100, 7'h03, 5, p); tot += p;
        hold(5'b01000, 7'h03, 5, p); tot += p;
        hold(5'b10000, 7'h03, 5, p); tot += p;
        check("stallResume", tot, 1);

        // Reset partway through the C2 dwell; only the scan after reset publishes.
        hold(5'b00001, 7'h01, 5, p);
        hold(5'b00010, 7'h01, 5, p);
        hold(5'b00100, 7'h01, 2, p);
        doReset(2);
        check("rstFrame", frameHi, 35'd0);
        tot = 0;
        hold(5'b00001, 7'h7f, 5, p); tot += p;
        hold(5'b00010, 7'h00, 5, p); tot += p;
        hold(5'b00100, 7'h7f, 5, p); tot += p;
        hold(5'b01000, 7'h00, 5, p); tot += p;
        hold(5'b10000, 7'h7f, 5, p); tot += p;
        check("rstScanPulses", tot, 1);
        check("rstScanFrame", frameHi, 35'h7_F01F_C07F);
        check("rstScanErrOrder", eoHi, 1'b0);

        // Random scans: mostly in order, with wrong columns, invalid patterns,
        // short holds, clears and the occasional reset mixed in.
        ptr = 0;
        for (int s = 0; s < 300; s++) begin
            r = $urandom_range(0, 99);
            if (r < 1) begin
                doReset(1);
                ptr = 0;
            end else if (r < 70) begin
                col = 5'b00001 << ptr;
                ptr = (ptr + 1) % 5;
            end else if (r < 80) begin
                col = 5'b00001 << $urandom_range(0, 4);
            end else if (r < 90) begin
                col = 5'($urandom);
            end
            row = 7'($urandom);
            clrErr = ($urandom_range(0, 19) == 0);
            hl = $urandom_range(1, 6);
            for (int k = 0; k < hl; k++) begin
                step();
                clrErr = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule
